// File: rtl/circuit2b_sweep_ctrl_pkg.sv
// Shared types and constants for the Circuit2B exhaustive sweep controller.
package circuit2b_pkg;

    localparam int NUM_VECTORS = 32;
    localparam int VEC_W       = 5;
    localparam int ERR_W       = 6;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DRIVE  = 3'd1,
        SETTLE = 3'd2,
        SAMPLE = 3'd3,
        DONE   = 3'd4
    } state_t;

    // A vector fails when either output disagrees with its expected table bit;
    // a double mismatch still counts as a single failing vector.
    function automatic logic vec_fails(
        input logic [NUM_VECTORS-1:0] exp_f,
        input logic [NUM_VECTORS-1:0] exp_g,
        input logic                   out_f,
        input logic                   out_g,
        input logic [VEC_W-1:0]       idx
    );
        return (out_f != exp_f[idx]) || (out_g != exp_g[idx]);
    endfunction

endpackage

// File: rtl/circuit2b_sweep_ctrl_if.sv
// Control/status bundle between the sweep controller and whoever launches runs.
interface circuit2b_sweep_ctrl_if;
    import circuit2b_pkg::*;

    logic                   start;
    logic                   abort;
    logic [NUM_VECTORS-1:0] exp_f;
    logic [NUM_VECTORS-1:0] exp_g;
    logic                   busy;
    logic                   done;
    logic                   pass;
    logic [ERR_W-1:0]       err_count;
    logic [VEC_W-1:0]       first_fail;
    logic                   first_fail_valid;

    // Caller side: requests runs and reads results.
    modport master (
        output start, abort, exp_f, exp_g,
        input  busy, done, pass, err_count, first_fail, first_fail_valid
    );

    // Controller side.
    modport slave (
        input  start, abort, exp_f, exp_g,
        output busy, done, pass, err_count, first_fail, first_fail_valid
    );

endinterface

// File: rtl/circuit2b_sweep_ctrl.sv
// Exhaustive sweep controller for Circuit2B: steps all 32 input vectors,
// waits SETTLE_CYCLES after each drive, scores OutF/OutG against latched
// expected tables and reports error count, lowest failing vector and pass.
module circuit2b_sweep_ctrl
    import circuit2b_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    circuit2b_sweep_ctrl_if.slave ctrl_if,
    output logic                  o_in_a,
    output logic                  o_in_b,
    output logic                  o_in_c,
    output logic                  o_in_d,
    output logic                  o_in_e,
    input  logic                  i_out_f,
    input  logic                  i_out_g
);

    // Settle counter runs 0..SETTLE_CYCLES-1; a zero setting skips SETTLE entirely.
    localparam int unsigned SETTLE_LAST_INT = (SETTLE_CYCLES == 32'd0) ? 32'd0 : (SETTLE_CYCLES - 32'd1);
    localparam logic [3:0]  SETTLE_LAST     = 4'(SETTLE_LAST_INT);
    localparam bit          NO_SETTLE       = (SETTLE_CYCLES == 32'd0);
    localparam logic [VEC_W-1:0] LAST_VEC   = VEC_W'(NUM_VECTORS - 1);

    state_t                 r_state;
    logic [VEC_W-1:0]       r_index;
    logic [3:0]             r_settle_cnt;
    logic [NUM_VECTORS-1:0] r_exp_f;
    logic [NUM_VECTORS-1:0] r_exp_g;
    logic [VEC_W-1:0]       r_in;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_pass;
    logic [ERR_W-1:0]       r_err_count;
    logic [VEC_W-1:0]       r_first_fail;
    logic                   r_first_fail_valid;
    logic                   w_fail;

    // Circuit2B is combinational, so its outputs reflect r_in directly.
    assign w_fail = vec_fails(r_exp_f, r_exp_g, i_out_f, i_out_g, r_index);

    // Sweep FSM: accepts runs, drives vectors, times settling, scores samples.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state            <= IDLE;
            r_index            <= {VEC_W{1'b0}};
            r_settle_cnt       <= 4'd0;
            r_exp_f            <= {NUM_VECTORS{1'b0}};
            r_exp_g            <= {NUM_VECTORS{1'b0}};
            r_in               <= {VEC_W{1'b0}};
            r_busy             <= 1'b0;
            r_done             <= 1'b0;
            r_pass             <= 1'b0;
            r_err_count        <= {ERR_W{1'b0}};
            r_first_fail       <= {VEC_W{1'b0}};
            r_first_fail_valid <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (ctrl_if.abort && (r_state != IDLE)) begin
                // Abort: release Circuit2B inputs, keep error statistics.
                r_state <= IDLE;
                r_in    <= {VEC_W{1'b0}};
                r_busy  <= 1'b0;
                r_pass  <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (ctrl_if.start && !ctrl_if.abort) begin
                            r_exp_f            <= ctrl_if.exp_f;
                            r_exp_g            <= ctrl_if.exp_g;
                            r_err_count        <= {ERR_W{1'b0}};
                            r_pass             <= 1'b0;
                            r_first_fail       <= {VEC_W{1'b0}};
                            r_first_fail_valid <= 1'b0;
                            r_index            <= {VEC_W{1'b0}};
                            r_busy             <= 1'b1;
                            r_state            <= DRIVE;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                    DRIVE: begin
                        r_in         <= r_index;
                        r_settle_cnt <= 4'd0;
                        r_state      <= NO_SETTLE ? SAMPLE : SETTLE;
                    end
                    SETTLE: begin
                        if (r_settle_cnt == SETTLE_LAST) begin
                            r_state <= SAMPLE;
                        end else begin
                            r_settle_cnt <= r_settle_cnt + 4'd1;
                        end
                    end
                    SAMPLE: begin
                        if (w_fail) begin
                            r_err_count <= r_err_count + 6'd1;
                            if (!r_first_fail_valid) begin
                                r_first_fail       <= r_index;
                                r_first_fail_valid <= 1'b1;
                            end else begin
                                r_first_fail_valid <= 1'b1;
                            end
                        end else begin
                            r_err_count <= r_err_count;
                        end
                        // The index stops at the last vector rather than wrapping.
                        if (r_index == LAST_VEC) begin
                            r_state <= DONE;
                        end else begin
                            r_index <= r_index + 5'd1;
                            r_state <= DRIVE;
                        end
                    end
                    DONE: begin
                        r_done  <= 1'b1;
                        r_pass  <= (r_err_count == {ERR_W{1'b0}});
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                    default: begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_in_a = r_in[4];
    assign o_in_b = r_in[3];
    assign o_in_c = r_in[2];
    assign o_in_d = r_in[1];
    assign o_in_e = r_in[0];

    assign ctrl_if.busy             = r_busy;
    assign ctrl_if.done             = r_done;
    assign ctrl_if.pass             = r_pass;
    assign ctrl_if.err_count        = r_err_count;
    assign ctrl_if.first_fail       = r_first_fail;
    assign ctrl_if.first_fail_valid = r_first_fail_valid;

endmodule

// File: tb/tb_circuit2b_sweep_ctrl.sv
// Bench for circuit2b_sweep_ctrl: two instances (settle 2 and settle 0) share
// stimulus; a timeline model checks every cycle, directed checks pin key values.
module tb_circuit2b_sweep_ctrl;

    localparam int SET_A = 2;
    localparam int SET_B = 0;
    localparam int PER_A = SET_A + 2;
    localparam int PER_B = SET_B + 2;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b0;
    logic        start  = 1'b0;
    logic        abort  = 1'b0;
    logic [31:0] exp_f  = 32'd0;
    logic [31:0] exp_g  = 32'd0;
    logic [31:0] gold_f;
    logic [31:0] gold_g;
    int          total  = 0;
    int          bad    = 0;

    always #5 clk = ~clk;

    circuit2b_sweep_ctrl_if if_a ();
    circuit2b_sweep_ctrl_if if_b ();

    assign if_a.start = start;
    assign if_a.abort = abort;
    assign if_a.exp_f = exp_f;
    assign if_a.exp_g = exp_g;
    assign if_b.start = start;
    assign if_b.abort = abort;
    assign if_b.exp_f = exp_f;
    assign if_b.exp_g = exp_g;

    // Stand-in Circuit2B: F = A&B | ~C&E, G = odd parity of all five inputs.
    function automatic logic circ_f(input logic [4:0] v);
        return (v[4] & v[3]) | (~v[2] & v[0]);
    endfunction
    function automatic logic circ_g(input logic [4:0] v);
        return ^v;
    endfunction

    logic [4:0] in_a_v;
    logic [4:0] in_b_v;
    logic       a_f, a_g, b_f, b_g;
    assign a_f = circ_f(in_a_v);
    assign a_g = circ_g(in_a_v);
    assign b_f = circ_f(in_b_v);
    assign b_g = circ_g(in_b_v);

    circuit2b_sweep_ctrl #(.SETTLE_CYCLES(SET_A)) dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .ctrl_if(if_a.slave),
        .o_in_a(in_a_v[4]), .o_in_b(in_a_v[3]), .o_in_c(in_a_v[2]),
        .o_in_d(in_a_v[1]), .o_in_e(in_a_v[0]),
        .i_out_f(a_f), .i_out_g(a_g)
    );

    circuit2b_sweep_ctrl #(.SETTLE_CYCLES(SET_B)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .ctrl_if(if_b.slave),
        .o_in_a(in_b_v[4]), .o_in_b(in_b_v[3]), .o_in_c(in_b_v[2]),
        .o_in_d(in_b_v[1]), .o_in_e(in_b_v[0]),
        .i_out_f(b_f), .i_out_g(b_g)
    );

    // Observed outputs: {busy, done, pass, err[5:0], first_fail[4:0], ffv, in[4:0]}.
    wire [19:0] act_a = {if_a.busy, if_a.done, if_a.pass, if_a.err_count,
                         if_a.first_fail, if_a.first_fail_valid, in_a_v};
    wire [19:0] act_b = {if_b.busy, if_b.done, if_b.pass, if_b.err_count,
                         if_b.first_fail, if_b.first_fail_valid, in_b_v};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // ---------------- timeline model ----------------
    // A run is a count t of edges since acceptance; vector v is driven at edge
    // v*P+1, sampled at edge (v+1)*P, and completion is reported at edge 32*P+1.
    bit         m_valid = 1'b0;
    bit         m_run   [2];
    int         m_t     [2];
    logic [4:0] m_in    [2];
    logic       m_busy  [2];
    logic       m_done  [2];
    logic       m_pass  [2];
    logic [5:0] m_err   [2];
    logic [4:0] m_ff    [2];
    logic       m_ffv   [2];
    logic [31:0] m_ef   [2];
    logic [31:0] m_eg   [2];

    function automatic int per_of(input int i);
        return (i == 0) ? PER_A : PER_B;
    endfunction

    function automatic logic vec_bad(input logic [31:0] ef, input logic [31:0] eg, input int v);
        logic [4:0] vv;
        vv = 5'(v);
        return (circ_f(vv) != ef[v]) || (circ_g(vv) != eg[v]);
    endfunction

    // Model update, one step per rising edge for each instance.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            m_done[i] <= 1'b0;
            if (!rst_n) begin
                m_valid   <= 1'b1;
                m_run[i]  <= 1'b0;
                m_t[i]    <= 0;
                m_in[i]   <= 5'd0;
                m_busy[i] <= 1'b0;
                m_pass[i] <= 1'b0;
                m_err[i]  <= 6'd0;
                m_ff[i]   <= 5'd0;
                m_ffv[i]  <= 1'b0;
                m_ef[i]   <= 32'd0;
                m_eg[i]   <= 32'd0;
            end else if (m_run[i] && abort) begin
                m_run[i]  <= 1'b0;
                m_in[i]   <= 5'd0;
                m_busy[i] <= 1'b0;
                m_pass[i] <= 1'b0;
            end else if (m_run[i]) begin
                m_t[i] <= m_t[i] + 1;
                if ((m_t[i] % per_of(i)) == 0 && (m_t[i] / per_of(i)) < 32)
                    m_in[i] <= 5'(m_t[i] / per_of(i));
                if (((m_t[i] + 1) % per_of(i)) == 0 && ((m_t[i] + 1) / per_of(i)) <= 32) begin
                    if (vec_bad(m_ef[i], m_eg[i], (m_t[i] + 1) / per_of(i) - 1)) begin
                        m_err[i] <= m_err[i] + 6'd1;
                        if (!m_ffv[i]) begin
                            m_ff[i]  <= 5'((m_t[i] + 1) / per_of(i) - 1);
                            m_ffv[i] <= 1'b1;
                        end
                    end
                end
                if (m_t[i] + 1 == 32 * per_of(i) + 1) begin
                    m_run[i]  <= 1'b0;
                    m_busy[i] <= 1'b0;
                    m_done[i] <= 1'b1;
                    m_pass[i] <= (m_err[i] == 6'd0);
                end
            end else if (start && !abort) begin
                m_run[i]  <= 1'b1;
                m_t[i]    <= 0;
                m_busy[i] <= 1'b1;
                m_pass[i] <= 1'b0;
                m_err[i]  <= 6'd0;
                m_ff[i]   <= 5'd0;
                m_ffv[i]  <= 1'b0;
                m_ef[i]   <= exp_f;
                m_eg[i]   <= exp_g;
            end
        end
    end

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (m_valid) begin
            chk("model_a", 32'(act_a), 32'({m_busy[0], m_done[0], m_pass[0], m_err[0], m_ff[0], m_ffv[0], m_in[0]}));
            chk("model_b", 32'(act_b), 32'({m_busy[1], m_done[1], m_pass[1], m_err[1], m_ff[1], m_ffv[1], m_in[1]}));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic kick(input logic [31:0] ef, input logic [31:0] eg, input bit hold);
        @(negedge clk);
        exp_f = ef;
        exp_g = eg;
        start = 1'b1;
        @(negedge clk);
        if (!hold) start = 1'b0;
    endtask

    // Counts edges since acceptance until instance A reports Done (bounded).
    task automatic wait_done(input int pulse_at, output int ta, output int tb, output logic [19:0] snap);
        ta   = -1;
        tb   = -1;
        snap = 20'd0;
        for (int n = 1; n <= 200 && ta < 0; n++) begin
            @(negedge clk);
            if (pulse_at > 0 && n == pulse_at) start = 1'b1;
            else if (pulse_at > 0 && n == pulse_at + 1) start = 1'b0;
            if (n == 1)  chk("first_drive_a", 32'({if_a.busy, in_a_v}), 32'({1'b1, 5'd0}));
            if (n == 21) chk("b_vec10_at_21", 32'(in_b_v), 32'd10);
            if (n == 29) chk("a_vec7_at_29", 32'(in_a_v), 32'd7);
            if (if_b.done && tb < 0) tb = n;
            if (if_a.done) begin
                ta   = n;
                snap = act_a;
            end
        end
    endtask

    initial begin
        int         ta, tb;
        logic [19:0] snap;
        bit         seen;
        bit         saw_done;

        for (int v = 0; v < 32; v++) begin
            gold_f[v] = circ_f(5'(v));
            gold_g[v] = circ_g(5'(v));
        end

        repeat (3) @(negedge clk);
        chk("reset_a", 32'(act_a), 32'd0);
        chk("reset_b", 32'(act_b), 32'd0);
        rst_n = 1'b1;

        // Golden tables: full pass, Done 128 cycles after first drive (64 for B).
        kick(gold_f, gold_g, 1'b0);
        wait_done(0, ta, tb, snap);
        chk("golden_time_a", 32'(ta), 32'd129);
        chk("golden_time_b", 32'(tb), 32'd65);
        chk("golden_result", 32'(snap), 32'({1'b0, 1'b1, 1'b1, 6'd0, 5'd0, 1'b0, 5'd31}));

        // Two flipped expectations: vectors 5 and 20 fail.
        kick(gold_f ^ (32'd1 << 5), gold_g ^ (32'd1 << 20), 1'b0);
        wait_done(0, ta, tb, snap);
        chk("flip_result", 32'(snap), 32'({1'b0, 1'b1, 1'b0, 6'd2, 5'd5, 1'b1, 5'd31}));
        chk("flip_model_err", 32'(m_err[0]), 32'd2);

        // Both tables inverted: 32 failing vectors, not 64.
        kick(~gold_f, ~gold_g, 1'b0);
        wait_done(0, ta, tb, snap);
        chk("inv_result", 32'(snap), 32'({1'b0, 1'b1, 1'b0, 6'd32, 5'd0, 1'b1, 5'd31}));

        // Abort while vector 10 is on the inputs.
        kick(gold_f, gold_g, 1'b0);
        seen = 1'b0;
        for (int n = 1; n <= 200 && !seen; n++) begin
            @(negedge clk);
            if (if_a.busy && in_a_v == 5'd10) seen = 1'b1;
        end
        chk("abort_reach_vec10", 32'(seen), 32'd1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_outputs", 32'({if_a.busy, if_a.done, if_a.pass, in_a_v}), 32'd0);
        saw_done = 1'b0;
        repeat (140) begin
            @(negedge clk);
            if (if_a.done || if_b.done) saw_done = 1'b1;
        end
        chk("abort_no_done", 32'(saw_done), 32'd0);

        kick(gold_f, gold_g, 1'b0);
        wait_done(0, ta, tb, snap);
        chk("after_abort_time", 32'(ta), 32'd129);
        chk("after_abort_result", 32'(snap), 32'({1'b0, 1'b1, 1'b1, 6'd0, 5'd0, 1'b0, 5'd31}));

        // Start pulsed mid-run is ignored; timing unchanged.
        kick(gold_f, gold_g, 1'b0);
        wait_done(50, ta, tb, snap);
        chk("midstart_time_a", 32'(ta), 32'd129);
        chk("midstart_time_b", 32'(tb), 32'd65);

        // Start held high: a new run is accepted right after the Done cycle.
        kick(gold_f, gold_g, 1'b1);
        wait_done(0, ta, tb, snap);
        chk("held_time_a", 32'(ta), 32'd129);
        @(negedge clk);
        start = 1'b0;
        chk("retrigger_busy", 32'({if_a.busy, if_a.done}), 32'({1'b1, 1'b0}));

        // Reset mid-run drops everything to reset values.
        repeat (30) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrun_reset_a", 32'(act_a), 32'd0);
        chk("midrun_reset_b", 32'(act_b), 32'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/circuit2b_sweep_ctrl.md
# circuit2b_sweep_ctrl

Self-checking exhaustive sweep controller for the Circuit2B five-input, two-output combinational block. On Start, it steps all 32 input vectors into Circuit2B, waits a programmable settle time, samples OutF/OutG and compares them against caller-supplied expected truth tables. It reports an error count, the first failing vector, and pass/fail. It sits beside the Circuit2B instance and owns its InA..InE inputs during a run.

## Interface
- SETTLE_CYCLES, default 2: wait cycles between driving a vector and sampling it; legal range 0..15.
- Clk  in  1  system clock; all state updates on the rising edge.
- Rst_n  in  1  synchronous, active-low reset.
- Start  in  1  run request; accepted only in IDLE.
- Abort  in  1  terminates a run; takes priority over Start.
- ExpF  in  32  expected OutF; bit i is the expected value for vector i. Latched on Start accept.
- ExpG  in  32  expected OutG; same encoding as ExpF.
- OutF, OutG  in  1 each  Circuit2B outputs.
- InA, InB, InC, InD, InE  out  1 each  Circuit2B inputs; vector v maps to InA=v[4] … InE=v[0].
- Busy  out  1  high from accept until the DONE or abort exit.
- Done  out  1  one-cycle pulse at run completion.
- Pass  out  1  set at completion if ErrCount==0; holds until the next accept or reset.
- ErrCount  out  6  number of failing vectors, 0..32.
- FirstFail  out  5  index of the lowest failing vector.
- FirstFailValid  out  1  FirstFail is meaningful.

## Operation
- Reset values: InA..InE=0, Busy=0, Done=0, Pass=0, ErrCount=0, FirstFail=0, FirstFailValid=0, state=IDLE, index=0.
- States: IDLE, DRIVE, SETTLE, SAMPLE, DONE.
- IDLE: Start=1 and Abort=0 → latch ExpF/ExpG, clear ErrCount, Pass, FirstFail and FirstFailValid, index=0 → DRIVE.
- DRIVE: In* = index (1 cycle) → SETTLE, or → SAMPLE if SETTLE_CYCLES==0.
- SETTLE: counts SETTLE_CYCLES cycles with In* stable → SAMPLE.
- SAMPLE: a vector fails if OutF≠ExpF[index] or OutG≠ExpG[index]. It counts once per vector, even if both outputs mismatch.
  - On a failure, ErrCount increments.
  - On the first failure, FirstFail=index and FirstFailValid=1.
  - If index==31 → DONE; otherwise index+1 → DRIVE. The 5-bit index never wraps inside a run.
- DONE: Done=1, Pass=(ErrCount==0) including the final sample, Busy=0 → IDLE.
- Abort in any non-IDLE state → IDLE next edge. Also In*=0, Busy=0, no Done, Pass=0; ErrCount and FirstFail* hold.
- Start while not in IDLE is ignored. Start held high re-triggers a new run in the cycle after DONE.
- Rst_n=0 mid-run → all reset values at that edge; the run is lost.

## Timing
- Start accepted at edge k: Busy=1 and In*=00000 after edge k+1.
- Each vector takes SETTLE_CYCLES+2 cycles (DRIVE + settle + SAMPLE).
- Done is high in cycle k+1+32·(SETTLE_CYCLES+2). With the default, that is 128 cycles after first drive.
- Circuit2B is combinational. Sampling on the SAMPLE edge sees outputs settled for at least SETTLE_CYCLES+1 cycles.
- ErrCount and FirstFail* update on the SAMPLE edge and are valid the following cycle.

## Structure
- Package circuit2b_pkg:
  - state enum (IDLE, DRIVE, SETTLE, SAMPLE, DONE)
  - NUM_VECTORS=32, VEC_W=5, ERR_W=6.
- Single flat module: FSM, 5-bit index, 4-bit settle counter, compare/accumulate logic.
- No sub-module is needed. The Circuit2B instance lives in the parent, not inside this block.

## Test plan
- Reset, then Start with ExpF/ExpG equal to the golden Circuit2B truth table (default SETTLE) → Done after 128 cycles, Pass=1, ErrCount=0, FirstFailValid=0.
- Golden tables with ExpF bit 5 and ExpG bit 20 inverted → ErrCount=2, FirstFail=5, FirstFailValid=1, Pass=0.
- ExpF = ~golden and ExpG = ~golden → ErrCount=32 (not 64), FirstFail=0, Pass=0.
- Abort while index=10 → next cycle Busy=0, In*=00000, no Done pulse. Start pulsed again → full run completes with Pass=1.
- Start pulsed mid-run → ignored, and completion timing is unchanged. Rst_n=0 mid-run → every output at its reset value after that edge.
- SETTLE_CYCLES=0 instance → Done 64 cycles after first drive. In* steps 00000→11111 every 2 cycles.
